// File: rtl/sync_counter_pkg.sv
// Shared types and configuration checks for the parametrised up/down counter.
// Latency: n/a (types and constants only). Backpressure: n/a.
package sync_counter_pkg;

  localparam int MAX_CNT_WIDTH = 32;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  // MODULUS must fit in WIDTH bits: $clog2(2**W) == W is the largest legal value.
  function automatic bit cnt_cfg_legal(input int width, input longint modulus);
    return (width >= 2) && (width <= MAX_CNT_WIDTH) &&
           (modulus >= 2) && ($clog2(modulus) <= width);
  endfunction

endpackage

// File: rtl/sync_updown_counter_bit_cell.sv
// One register bit of the count, with q and its complement held as separate flops.
// Latency: 1 cycle. Backpressure: none; priority is reset > clr > ld > toggle > hold.
module cnt_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic ld,
  input  logic ld_val,
  input  logic t,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q  <= 1'b0;
      qb <= 1'b1;
    end else if (clr) begin
      q  <= 1'b0;
      qb <= 1'b1;
    end else if (ld) begin
      q  <= ld_val;
      qb <= ~ld_val;
    end else if (t) begin
      q  <= ~q;
      qb <= q;
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Modulo-N up/down counter with load, clear, wrap/saturate; optional snapshot via SYNC_UPDOWN_COUNTER_SNAPSHOT_EN.
// Latency: 1 cycle input to q, tc combinational. Backpressure: none, accepts controls every cycle.
module sync_updown_counter
  import sync_counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = longint'(1) << WIDTH,
  parameter int     SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef SYNC_UPDOWN_COUNTER_SNAPSHOT_EN
  input  logic             snap_req,
  output logic [WIDTH-1:0] snap_q,
  output logic             snap_vld,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  if (!cnt_cfg_legal(WIDTH, MODULUS)) begin : g_bad_cfg
    $error("sync_updown_counter: illegal WIDTH/MODULUS combination");
  end
  if (SATURATE != 0 && SATURATE != 1) begin : g_bad_sat
    $error("sync_updown_counter: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  cnt_dir_e         dir;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] load_clamped;
  logic             wrap_nxt;
  logic             sat_nxt;

  assign dir          = cnt_dir_e'(up_dn);
  assign at_max       = (q == MAX_Q);
  assign at_zero      = (q == '0);
  assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;
  assign tc           = en && (((dir == CNT_UP) && at_max) || ((dir == CNT_DOWN) && at_zero));

  always_comb begin
    nxt      = q;
    wrap_nxt = 1'b0;
    sat_nxt  = 1'b0;
    if (en) begin
      if (dir == CNT_UP) begin
        if (!at_max)             nxt = q + ONE;
        else if (SATURATE != 0)  sat_nxt = 1'b1;
        else begin
          nxt      = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!at_zero)            nxt = q - ONE;
        else if (SATURATE != 0)  sat_nxt = 1'b1;
        else begin
          nxt      = MAX_Q;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  // Counting is expressed as per-bit toggles; load/clear override inside each cell.
  assign tgl = q ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cnt_bit_cell u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clear),
      .ld     (load),
      .ld_val (load_clamped[i]),
      .t      (tgl[i]),
      .q      (q[i]),
      .qb     (qb[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear || load) begin
      wrap <= 1'b0;
      sat  <= 1'b0;
    end else begin
      wrap <= wrap_nxt;
      sat  <= sat_nxt;
    end
  end

`ifdef SYNC_UPDOWN_COUNTER_SNAPSHOT_EN
  // Captures the pre-update count; the valid flag is sticky until clear or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q   <= '0;
      snap_vld <= 1'b0;
    end else if (clear) begin
      snap_vld <= 1'b0;
    end else if (snap_req) begin
      snap_q   <= q;
      snap_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed vector bench for sync_updown_counter: wrapping and saturating instances, WIDTH=4, MODULUS=10.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0, en = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] q, qb;
  logic       tc, wrap, sat;

  logic       s_rst_n = 1'b0, s_en = 1'b0, s_up_dn = 1'b1, s_clear = 1'b0, s_load = 1'b0;
  logic [3:0] s_load_val = 4'd0;
  logic [3:0] s_q, s_qb;
  logic       s_tc, s_wrap, s_sat;

`ifdef SYNC_UPDOWN_COUNTER_SNAPSHOT_EN
  logic       snap_req = 1'b0, s_snap_req = 1'b0;
  logic [3:0] snap_q, s_snap_q;
  logic       snap_vld, s_snap_vld;
`endif

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val),
`ifdef SYNC_UPDOWN_COUNTER_SNAPSHOT_EN
    .snap_req(snap_req), .snap_q(snap_q), .snap_vld(snap_vld),
`endif
    .q(q), .qb(qb), .tc(tc), .wrap(wrap), .sat(sat)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .en(s_en), .up_dn(s_up_dn), .clear(s_clear), .load(s_load),
    .load_val(s_load_val),
`ifdef SYNC_UPDOWN_COUNTER_SNAPSHOT_EN
    .snap_req(s_snap_req), .snap_q(s_snap_q), .snap_vld(s_snap_vld),
`endif
    .q(s_q), .qb(s_qb), .tc(s_tc), .wrap(s_wrap), .sat(s_sat)
  );

  typedef struct {
    logic       rst_n, en, up_dn, clear, load;
    logic [3:0] load_val;
    logic       exp_tc;
    logic [3:0] exp_q;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic u, input logic c, input logic l,
                     input logic [3:0] lv, input logic t, input logic [3:0] eq, input logic w);
    vec_t v;
    v.rst_n = r; v.en = e; v.up_dn = u; v.clear = c; v.load = l; v.load_val = lv;
    v.exp_tc = t; v.exp_q = eq; v.exp_wrap = w;
    vecs.push_back(v);
  endtask

  // Saturating instance: drive, check tc before the edge, then q/qb/sat/wrap after it.
  task automatic step_s(input logic e, input logic u, input logic l, input logic [3:0] lv,
                        input logic t, input logic [3:0] eq, input logic es);
    logic [3:0] eqb;
    @(negedge clk);
    s_rst_n = 1'b1; s_en = e; s_up_dn = u; s_load = l; s_load_val = lv;
    #1 chk("sat_tc", s_tc, t);
    @(posedge clk);
    #1;
    eqb = ~eq;
    chk("sat_q", s_q, eq);
    chk("sat_qb", s_qb, eqb);
    chk("sat_sat", s_sat, es);
    chk("sat_wrap", s_wrap, 1'b0);
  endtask

  initial begin
    logic [3:0] eqb;

    //   rst en up clr ld lv   tc  q  wrap
    add(0, 0, 1, 0, 0, 4'd0, 0, 4'd0, 0);
    for (int k = 1; k <= 9; k++)
      add(1, 1, 1, 0, 0, 4'd0, 0, 4'(k), 0);
    add(1, 1, 1, 0, 0, 4'd0,  1, 4'd0, 1);  // 9 -> 0 wraps
    add(1, 1, 1, 0, 0, 4'd0,  0, 4'd1, 0);  // pulse lasts one cycle
    add(1, 1, 0, 0, 0, 4'd0,  0, 4'd0, 0);
    add(1, 1, 0, 0, 0, 4'd0,  1, 4'd9, 1);  // 0 -> 9 wraps down
    add(1, 0, 0, 0, 0, 4'd0,  0, 4'd9, 0);
    add(1, 1, 0, 0, 0, 4'd0,  0, 4'd8, 0);
    add(1, 0, 1, 0, 1, 4'd12, 0, 4'd9, 0);  // load clamps to 9
    add(1, 1, 1, 0, 1, 4'd12, 1, 4'd9, 0);  // load beats wrapping count
    add(1, 0, 1, 0, 1, 4'd5,  0, 4'd5, 0);
    add(1, 0, 1, 1, 1, 4'd7,  0, 4'd0, 0);  // clear beats load
    add(1, 0, 1, 0, 1, 4'd5,  0, 4'd5, 0);
    add(1, 1, 1, 0, 0, 4'd0,  0, 4'd6, 0);
    add(0, 1, 1, 0, 0, 4'd0,  0, 4'd0, 0);  // reset mid-count
    add(1, 0, 1, 0, 1, 4'd9,  0, 4'd9, 0);
    add(1, 0, 1, 1, 0, 4'd0,  0, 4'd0, 0);
    add(1, 0, 1, 0, 1, 4'd10, 0, 4'd9, 0);  // one past the top clamps
    add(1, 1, 1, 0, 0, 4'd0,  1, 4'd0, 1);
    add(1, 1, 1, 1, 0, 4'd0,  0, 4'd0, 0);  // clear beats count, kills pulse

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; en = vecs[i].en; up_dn = vecs[i].up_dn;
      clear = vecs[i].clear; load = vecs[i].load; load_val = vecs[i].load_val;
      #1 chk($sformatf("tc[%0d]", i), tc, vecs[i].exp_tc);
      @(posedge clk);
      #1;
      eqb = ~vecs[i].exp_q;
      chk($sformatf("q[%0d]", i), q, vecs[i].exp_q);
      chk($sformatf("qb[%0d]", i), qb, eqb);
      chk($sformatf("wrap[%0d]", i), wrap, vecs[i].exp_wrap);
      chk($sformatf("sat_off[%0d]", i), sat, 1'b0);
    end

    // A low pulse on rst_n that never spans a rising edge must be ignored.
    @(negedge clk);
    clear = 1'b0; load = 1'b1; load_val = 4'd5; en = 1'b0;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("glitch_q", q, 4'd5);

`ifdef SYNC_UPDOWN_COUNTER_SNAPSHOT_EN
    @(negedge clk);
    load = 1'b1; load_val = 4'd6;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up_dn = 1'b1; snap_req = 1'b1;
    @(posedge clk);
    #1;
    chk("snap_q", snap_q, 4'd6);
    chk("snap_vld", snap_vld, 1'b1);
    chk("snap_cnt", q, 4'd7);
    @(negedge clk);
    en = 1'b0; snap_req = 1'b0;
    @(posedge clk);
    #1 chk("snap_sticky", snap_vld, 1'b1);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 chk("snap_clr", snap_vld, 1'b0);
    @(negedge clk);
    clear = 1'b0;
`endif

    // Saturating instance: reset, then hold at each boundary.
    @(negedge clk);
    s_rst_n = 1'b0;
    @(posedge clk);
    #1 chk("sat_rst_q", s_q, 4'd0);
    //       en up ld lv    tc  q     sat
    step_s(0, 1, 1, 4'd7, 0, 4'd7, 0);
    step_s(1, 1, 0, 4'd0, 0, 4'd8, 0);
    step_s(1, 1, 0, 4'd0, 0, 4'd9, 0);
    step_s(1, 1, 0, 4'd0, 1, 4'd9, 1);
    step_s(1, 1, 0, 4'd0, 1, 4'd9, 1);
    step_s(1, 1, 0, 4'd0, 1, 4'd9, 1);
    step_s(0, 1, 0, 4'd0, 0, 4'd9, 0);
    step_s(1, 0, 0, 4'd0, 0, 4'd8, 0);
    step_s(0, 0, 1, 4'd0, 0, 4'd0, 0);
    step_s(1, 0, 0, 4'd0, 1, 4'd0, 1);
    step_s(1, 1, 0, 4'd0, 0, 4'd1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
